// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 decode types: control bundle, immediate select, ALU op and opcode encodings
package riscv_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
    logic       alu_src;
  } ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard detection between decode and execute slots
module hazard_detect (
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hz
);

  // rs2 is compared even for I-type instructions; a spurious stall is harmless
  assign hz = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion, flush, hold and bubble counter
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic [7:0]       id_ctrl,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic [7:0]       ex_ctrl,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);

  ctrl_t ex_ctrl_q;
  logic  hz;

  assign ex_ctrl = ex_ctrl_q;

  hazard_detect u_hazard_detect (
    .id_valid    (id_valid),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl_q.mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .hz          (hz)
  );

  // Under hold the whole front end is already frozen, so no local stall is needed
  assign load_use_stall = hz & ~flush & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_funct     <= '0;
      ex_ctrl_q    <= '0;
      bubble_count <= '0;
    end else if (flush || (!hold && hz)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
      ex_ctrl_q   <= '0;
      if (!flush && (bubble_count != {CNT_W{1'b1}})) begin
        bubble_count <= bubble_count + CNT_W'(1);
      end
    end else if (!hold) begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
      // an invalid slot must never carry live control
      ex_ctrl_q   <= id_valid ? ctrl_t'(id_ctrl) : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking directed bench for id_ex_stage
module tb_id_ex_stage;

  localparam logic [7:0] C_LW  = 8'hD1;
  localparam logic [7:0] C_ADD = 8'h84;
  localparam logic [7:0] C_ADI = 8'h85;
  localparam logic [7:0] C_SW  = 8'h21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, flush, hold;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic [7:0]  id_ctrl;

  logic        ex_valid, load_use_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [7:0]  ex_ctrl;
  logic [15:0] bubble_count;

  logic        ex_valid4, load_use_stall4;
  logic [31:0] ex_pc4, ex_rs1_data4, ex_rs2_data4, ex_imm4;
  logic [4:0]  ex_rs14, ex_rs24, ex_rd4;
  logic [3:0]  ex_funct4;
  logic [7:0]  ex_ctrl4;
  logic [3:0]  bubble_count4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct(ex_funct), .ex_ctrl(ex_ctrl), .load_use_stall(load_use_stall),
    .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold), .ex_valid(ex_valid4),
    .ex_pc(ex_pc4), .ex_rs1_data(ex_rs1_data4), .ex_rs2_data(ex_rs2_data4),
    .ex_imm(ex_imm4), .ex_rs1(ex_rs14), .ex_rs2(ex_rs24), .ex_rd(ex_rd4),
    .ex_funct(ex_funct4), .ex_ctrl(ex_ctrl4), .load_use_stall(load_use_stall4),
    .bubble_count(bubble_count4)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        fl, hd;
    logic        e_stall, e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [31:0] e_imm;
    logic [7:0]  e_ctrl;
    int          e_bc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [31:0] imm, logic [7:0] ctrl, logic fl,
                              logic hd, logic e_stall, logic e_valid, logic [31:0] e_pc,
                              logic [4:0] e_rs1, logic [4:0] e_rs2, logic [4:0] e_rd,
                              logic [31:0] e_imm, logic [7:0] e_ctrl, int e_bc);
    vec_t r;
    r.v = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm; r.ctrl = ctrl;
    r.fl = fl; r.hd = hd; r.e_stall = e_stall; r.e_valid = e_valid; r.e_pc = e_pc;
    r.e_rs1 = e_rs1; r.e_rs2 = e_rs2; r.e_rd = e_rd; r.e_imm = e_imm; r.e_ctrl = e_ctrl;
    r.e_bc = e_bc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // operand data and funct are derived from pc so a single expected pc covers them
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                       input logic [7:0] ctrl, input logic fl, input logic hd);
    id_valid = v; id_pc = pc; id_rs1_data = pc + 32'h1000; id_rs2_data = pc + 32'h2000;
    id_imm = imm; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_funct = pc[5:2];
    id_ctrl = ctrl; flush = fl; hold = hd;
  endtask

  task automatic check_ex(input string tag, input vec_t r);
    int sat;
    sat = (r.e_bc > 15) ? 15 : r.e_bc;
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'(r.e_valid));
    chk({tag, ".ex_pc"}, ex_pc, r.e_pc);
    chk({tag, ".ex_rs1_data"}, ex_rs1_data, (r.e_pc != 0) ? r.e_pc + 32'h1000 : 32'h0);
    chk({tag, ".ex_rs2_data"}, ex_rs2_data, (r.e_pc != 0) ? r.e_pc + 32'h2000 : 32'h0);
    chk({tag, ".ex_funct"}, 32'(ex_funct), 32'(r.e_pc[5:2]));
    chk({tag, ".ex_rs1"}, 32'(ex_rs1), 32'(r.e_rs1));
    chk({tag, ".ex_rs2"}, 32'(ex_rs2), 32'(r.e_rs2));
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'(r.e_rd));
    chk({tag, ".ex_imm"}, ex_imm, r.e_imm);
    chk({tag, ".ex_ctrl"}, 32'(ex_ctrl), 32'(r.e_ctrl));
    chk({tag, ".bubble_count"}, 32'(bubble_count), 32'(r.e_bc));
    chk({tag, ".bubble_count4"}, 32'(bubble_count4), 32'(sat));
  endtask

  task automatic step(input string tag, input vec_t r);
    @(negedge clk);
    drive(r.v, r.pc, r.rs1, r.rs2, r.rd, r.imm, r.ctrl, r.fl, r.hd);
    #1;
    chk({tag, ".load_use_stall"}, 32'(load_use_stall), 32'(r.e_stall));
    @(posedge clk);
    #1;
    check_ex(tag, r);
  endtask

  initial begin
    // Reset with live inputs: nothing may be captured
    rst_n = 1'b0;
    drive(1'b1, 32'h55, 5'd5, 5'd6, 5'd7, 32'h99, C_LW, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_ex("reset", mk(0,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0,0,0,8'h0,0));
    chk("reset.load_use_stall", 32'(load_use_stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //          v pc      rs1 rs2 rd imm    ctrl  fl hd | st ev epc     ers1 ers2 erd eimm  ectrl bc
    vecs.push_back(mk(1,32'h100,1,2,3,32'h0,C_ADD,0,0, 0,1,32'h100,1,2,3,32'h0,C_ADD,0));
    vecs.push_back(mk(1,32'h104,1,0,5,32'h4,C_ADI,0,0, 0,1,32'h104,1,0,5,32'h4,C_ADI,0));
    vecs.push_back(mk(1,32'h108,1,0,5,32'h8,C_LW ,0,0, 0,1,32'h108,1,0,5,32'h8,C_LW ,0));
    vecs.push_back(mk(1,32'h10C,5,2,6,32'h0,C_ADD,0,0, 1,0,32'h0  ,0,0,0,32'h0,8'h00,1));
    vecs.push_back(mk(1,32'h10C,5,2,6,32'h0,C_ADD,0,0, 0,1,32'h10C,5,2,6,32'h0,C_ADD,1));
    vecs.push_back(mk(1,32'h110,1,0,0,32'h0,C_LW ,0,0, 0,1,32'h110,1,0,0,32'h0,C_LW ,1));
    vecs.push_back(mk(1,32'h114,0,0,8,32'h0,C_ADD,0,0, 0,1,32'h114,0,0,8,32'h0,C_ADD,1));
    vecs.push_back(mk(1,32'h118,1,0,7,32'h0,C_LW ,0,0, 0,1,32'h118,1,0,7,32'h0,C_LW ,1));
    vecs.push_back(mk(1,32'h11C,3,4,9,32'h0,C_ADD,0,0, 0,1,32'h11C,3,4,9,32'h0,C_ADD,1));
    vecs.push_back(mk(1,32'h120,1,0,5,32'hC,C_LW ,0,0, 0,1,32'h120,1,0,5,32'hC,C_LW ,1));
    vecs.push_back(mk(1,32'h124,2,5,6,32'h0,C_ADD,1,0, 0,0,32'h0  ,0,0,0,32'h0,8'h00,1));
    vecs.push_back(mk(1,32'h128,1,0,5,32'h10,C_LW,0,0, 0,1,32'h128,1,0,5,32'h10,C_LW,1));
    for (int h = 0; h < 3; h++)
      vecs.push_back(mk(1,32'h12C,5,0,6,32'h0,C_ADD,0,1, 0,1,32'h128,1,0,5,32'h10,C_LW,1));
    vecs.push_back(mk(1,32'h12C,5,0,6,32'h0,C_ADD,0,0, 1,0,32'h0  ,0,0,0,32'h0,8'h00,2));
    vecs.push_back(mk(1,32'h12C,5,0,6,32'h0,C_ADD,0,0, 0,1,32'h12C,5,0,6,32'h0,C_ADD,2));
    vecs.push_back(mk(0,32'h130,6,0,7,32'h0,C_LW ,0,0, 0,0,32'h130,6,0,7,32'h0,8'h00,2));
    vecs.push_back(mk(1,32'h134,1,0,9,32'h0,C_LW ,0,0, 0,1,32'h134,1,0,9,32'h0,C_LW ,2));
    vecs.push_back(mk(1,32'h138,2,9,0,32'h0,C_SW ,0,0, 1,0,32'h0  ,0,0,0,32'h0,8'h00,3));
    vecs.push_back(mk(1,32'h138,2,9,0,32'h0,C_SW ,0,0, 0,1,32'h138,2,9,0,32'h0,C_SW ,3));

    foreach (vecs[i]) step($sformatf("v%0d", i), vecs[i]);

    // 17 load-use pairs: 16-bit counter keeps counting, 4-bit counter pins at 0xF
    for (int p = 0; p < 17; p++) begin
      @(negedge clk);
      drive(1'b1, 32'h200 + 32'(p) * 16, 5'd1, 5'd0, 5'd5, 32'h0, C_LW, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b1, 32'h204 + 32'(p) * 16, 5'd5, 5'd2, 5'd6, 32'h0, C_ADD, 1'b0, 1'b0);
      #1;
      chk($sformatf("sat%0d.load_use_stall", p), 32'(load_use_stall), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("sat%0d.bubble_count", p), 32'(bubble_count), 32'(4 + p));
      chk($sformatf("sat%0d.bubble_count4", p), 32'(bubble_count4), (4 + p > 15) ? 32'd15 : 32'(4 + p));
      @(negedge clk); #1;
      chk($sformatf("sat%0d.stall_clear", p), 32'(load_use_stall), 32'h0);
      @(posedge clk);
    end
    #1;
    chk("sat.ex_ctrl_after", 32'(ex_ctrl), 32'(C_ADD));

    // Asynchronous reset in the middle of a stall clears without waiting for an edge
    @(negedge clk);
    drive(1'b1, 32'h2F0, 5'd1, 5'd0, 5'd5, 32'h0, C_LW, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h2F4, 5'd5, 5'd0, 5'd6, 32'h0, C_ADD, 1'b0, 1'b0);
    #1;
    chk("midrst.stall_before", 32'(load_use_stall), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.load_use_stall", 32'(load_use_stall), 32'h0);
    chk("midrst.ex_valid", 32'(ex_valid), 32'h0);
    chk("midrst.ex_ctrl", 32'(ex_ctrl), 32'h0);
    chk("midrst.ex_pc", ex_pc, 32'h0);
    chk("midrst.bubble_count", 32'(bubble_count), 32'h0);
    chk("midrst.bubble_count4", 32'(bubble_count4), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h300, 5'd1, 5'd2, 5'd3, 32'h7, C_ADD, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_ex("postrst", mk(0,0,0,0,0,0,0,0,0, 0,1,32'h300,1,2,3,32'h7,C_ADD,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
